half_adder_pipe: RTL and testbench
==================================

# half_adder_pipe

Registered, lane-parallel half adder for the ALU datapath. Each lane computes sum = a XOR b and carry c_out = a AND b. Results are held in a one-entry output register with a valid/ready handshake, so ripple and carry-select adder stages can build on top of it.

## Interface
Parameters:
- WIDTH, default 1: number of independent half-adder lanes (minimum 1).
- CNT_W, default 16: width of the carry-event counter. Used only when HA_CARRY_COUNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock; the block's one clock.
- rst_n  input  1  reset; asynchronous, active-low.
- in_valid  input  1  a and b are presented this cycle.
- in_ready  output  1  block accepts the operands this cycle.
- a  input  WIDTH  operand A, one bit per lane.
- b  input  WIDTH  operand B, one bit per lane.
- out_valid  output  1  sum and c_out hold a result.
- out_ready  input  1  downstream consumes the result this cycle.
- sum  output  WIDTH  registered a XOR b, per lane.
- c_out  output  WIDTH  registered a AND b, per lane.
- carry_cnt  output  CNT_W  saturating count of accepted lanes with carry. Present only with HA_CARRY_COUNT_EN.

## Operation
- Lanes are independent. For lane i: sum[i] = a[i] ^ b[i] and c_out[i] = a[i] & b[i]. There is no carry between lanes.
- Accept condition: in_valid && in_ready.
- in_ready = !out_valid || out_ready. This is combinational, so a full register can be refilled in the same cycle it drains.
- On accept, sum and c_out load the results on the next rising edge and out_valid is set to 1.
- On out_valid && out_ready with no accept in that cycle, out_valid clears to 0. sum and c_out keep their last values.
- While out_valid && !out_ready, sum, c_out and out_valid hold and in_ready is 0. Operands presented in this state are ignored, not queued.
- When in_valid is 0, a and b are don't-care and do not affect any state.
- Reset (rst_n low, at any time, including mid-transfer):
  - out_valid, sum and c_out go to 0 immediately, without waiting for a clock edge.
  - carry_cnt goes to 0.
  - in_ready therefore reads 1 during reset.
  - The first accept is possible on the first rising edge after rst_n deasserts.

## Timing
- Latency is 1 cycle from accept to out_valid.
- Throughput is 1 result per cycle while out_ready stays high.
- No combinational path from a or b to sum or c_out.
- The only combinational path is out_ready -> in_ready.
- Simultaneous drain and accept in one cycle: the register loads the new result and out_valid stays 1.

## Configuration
- Macro HA_CARRY_COUNT_EN.
- When defined:
  - carry_cnt is present.
  - On each accept, carry_cnt increments by the popcount of (a & b) across lanes.
  - It saturates at all-ones and never wraps.
  - It resets asynchronously to 0.
- When undefined: the carry_cnt port and counter logic are absent, and all other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 3 cycles -> out_valid=0, sum=0, c_out=0, in_ready=1. With the macro on, carry_cnt=0.
- Truth table, WIDTH=1, out_ready=1: apply (a,b) = 00, 01, 10, 11 on consecutive cycles -> one cycle later each, (sum,c_out) = (0,0), (1,0), (1,0), (0,1).
- Lanes, WIDTH=4: a=4'b1100, b=4'b1010 -> sum=4'b0110, c_out=4'b1000.
- Backpressure: accept a=1, b=1, then hold out_ready=0 while applying a=0, b=1 -> in_ready=0 and outputs stay sum=0, c_out=1. Raising out_ready then drains, and the next accepted pair (0,1) gives sum=1, c_out=0.
- Async reset mid-transfer: assert rst_n low between clock edges while out_valid=1 -> outputs clear immediately, and the next cycle's pending operands are not captured.
- Counter (macro on, CNT_W=2, WIDTH=4): accept a=b=4'b1111 -> carry_cnt saturates at 3, and it stays 3 after further accepts.

Source files
------------

// File: rtl/half_adder_pipe.sv
// Lane-parallel half adder with a one-entry valid/ready output register.
// Optional saturating carry-event counter enabled by `HA_CARRY_COUNT_EN.
module half_adder_pipe #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef HA_CARRY_COUNT_EN
  output logic [WIDTH-1:0] c_out,
  output logic [CNT_W-1:0] carry_cnt
`else
  output logic [WIDTH-1:0] c_out
`endif
);

  logic             r_valid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_cout;
  logic             w_accept;

  // A full register may be refilled in the same cycle it drains.
  assign in_ready  = !r_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_valid;
  assign sum       = r_sum;
  assign c_out     = r_cout;

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears outputs without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_sum   <= '0;
      r_cout  <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_sum   <= a ^ b;
      r_cout  <= a & b;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

`ifdef HA_CARRY_COUNT_EN
  localparam int PW = $clog2(WIDTH + 1);
  localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    w_pop;
  logic [SW-1:0]    w_cnt_sum;
  logic [SW-1:0]    w_cnt_max;
  logic [WIDTH-1:0] w_and;

  assign w_and     = a & b;
  assign w_cnt_max = SW'({CNT_W{1'b1}});
  assign w_cnt_sum = SW'(r_cnt) + SW'(w_pop);
  assign carry_cnt = r_cnt;

  // NOTE: combinational blocks assign a default first so no latch is inferred.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PW'(w_and[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      // Extra headroom bit lets the compare catch overflow before it wraps.
      r_cnt <= (w_cnt_sum > w_cnt_max) ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
    end
  end
`endif

endmodule

// File: tb/tb_half_adder_pipe.sv
// Directed bench for half_adder_pipe: WIDTH=1 truth table/handshake/reset,
// WIDTH=4 lanes, and (with HA_CARRY_COUNT_EN) a CNT_W=2 saturating counter.
module tb_half_adder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // WIDTH=1 instance
  logic s_iv = 1'b0, s_ir, s_ov, s_or = 1'b1;
  logic [0:0] s_a = '0, s_b = '0, s_sum, s_cout;
  // WIDTH=4 instance
  logic l_iv = 1'b0, l_ir, l_ov, l_or = 1'b1;
  logic [3:0] l_a = '0, l_b = '0, l_sum, l_cout;
`ifdef HA_CARRY_COUNT_EN
  logic [15:0] s_cnt, l_cnt;
  logic c_iv = 1'b0, c_ir, c_ov, c_or = 1'b1;
  logic [3:0] c_a = '0, c_b = '0, c_sum, c_cout;
  logic [1:0] c_cnt;
`endif

  half_adder_pipe #(.WIDTH(1)) u_single (
    .clk(clk), .rst_n(rst_n), .in_valid(s_iv), .in_ready(s_ir),
    .a(s_a), .b(s_b), .out_valid(s_ov), .out_ready(s_or),
`ifdef HA_CARRY_COUNT_EN
    .carry_cnt(s_cnt),
`endif
    .sum(s_sum), .c_out(s_cout)
  );

  half_adder_pipe #(.WIDTH(4)) u_lanes (
    .clk(clk), .rst_n(rst_n), .in_valid(l_iv), .in_ready(l_ir),
    .a(l_a), .b(l_b), .out_valid(l_ov), .out_ready(l_or),
`ifdef HA_CARRY_COUNT_EN
    .carry_cnt(l_cnt),
`endif
    .sum(l_sum), .c_out(l_cout)
  );

`ifdef HA_CARRY_COUNT_EN
  half_adder_pipe #(.WIDTH(4), .CNT_W(2)) u_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir),
    .a(c_a), .b(c_b), .out_valid(c_ov), .out_ready(c_or),
    .carry_cnt(c_cnt), .sum(c_sum), .c_out(c_cout)
  );
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_single(input string tag, input logic v, input logic s, input logic c);
    check({tag, ".valid"}, 32'(s_ov), 32'(v));
    check({tag, ".sum"},   32'(s_sum), 32'(s));
    check({tag, ".cout"},  32'(s_cout), 32'(c));
  endtask

  initial begin
    // Reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    check_single("reset", 1'b0, 1'b0, 1'b0);
    check("reset.in_ready", 32'(s_ir), 32'd1);
    check("reset.lane_valid", 32'(l_ov), 32'd0);
`ifdef HA_CARRY_COUNT_EN
    check("reset.carry_cnt", 32'(c_cnt), 32'd0);
`endif
    rst_n = 1'b1;

    // Truth table, back-to-back accepts
    s_iv = 1'b1; s_a = 1'b0; s_b = 1'b0; tick(); check_single("tt00", 1'b1, 1'b0, 1'b0);
    s_a = 1'b0; s_b = 1'b1; tick(); check_single("tt01", 1'b1, 1'b1, 1'b0);
    s_a = 1'b1; s_b = 1'b0; tick(); check_single("tt10", 1'b1, 1'b1, 1'b0);
    s_a = 1'b1; s_b = 1'b1; tick(); check_single("tt11", 1'b1, 1'b0, 1'b1);

    // Drain with no accept: valid drops, data held; a/b are don't-care
    s_iv = 1'b0; s_a = 1'b0; s_b = 1'b1; tick(); check_single("drain", 1'b0, 1'b0, 1'b1);

    // Backpressure
    s_iv = 1'b1; s_a = 1'b1; s_b = 1'b1; tick(); check_single("bp.load", 1'b1, 1'b0, 1'b1);
    s_or = 1'b0; s_a = 1'b0; s_b = 1'b1; #1;
    check("bp.in_ready_low", 32'(s_ir), 32'd0);
    tick(); check_single("bp.hold1", 1'b1, 1'b0, 1'b1);
    tick(); check_single("bp.hold2", 1'b1, 1'b0, 1'b1);
    s_or = 1'b1; #1;
    check("bp.in_ready_comb", 32'(s_ir), 32'd1);
    tick(); check_single("bp.refill", 1'b1, 1'b1, 1'b0);

    // Async reset mid-cycle while full, with pending operands
    s_or = 1'b0; s_a = 1'b1; s_b = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check_single("areset", 1'b0, 1'b0, 1'b0);
    check("areset.in_ready", 32'(s_ir), 32'd1);
    s_or = 1'b1;
    tick(); check_single("areset.held", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1; s_iv = 1'b0;
    tick(); check_single("areset.no_capture", 1'b0, 1'b0, 1'b0);
    s_iv = 1'b1; s_a = 1'b1; s_b = 1'b0;
    tick(); check_single("areset.first_accept", 1'b1, 1'b1, 1'b0);
    s_iv = 1'b0;

    // Lane independence
    l_iv = 1'b1; l_a = 4'b1100; l_b = 4'b1010; tick();
    check("lanes1.sum", 32'(l_sum), 32'b0110);
    check("lanes1.cout", 32'(l_cout), 32'b1000);
    l_a = 4'b1111; l_b = 4'b0101; tick();
    check("lanes2.sum", 32'(l_sum), 32'b1010);
    check("lanes2.cout", 32'(l_cout), 32'b0101);
    check("lanes2.valid", 32'(l_ov), 32'd1);
    l_iv = 1'b0;

`ifdef HA_CARRY_COUNT_EN
    // Counter: 1 carry, then 4 more must saturate at 3 rather than wrap
    c_iv = 1'b1; c_a = 4'b0001; c_b = 4'b0011; tick();
    check("cnt.one", 32'(c_cnt), 32'd1);
    c_a = 4'b1111; c_b = 4'b1111; tick();
    check("cnt.sat", 32'(c_cnt), 32'd3);
    tick();
    check("cnt.stay", 32'(c_cnt), 32'd3);
    c_iv = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
